// File: rtl/io_wait_gen_pkg.sv
// Shared MSX I/O map for the vg8020 decoders, plus the I/O access qualifier.
// FSM encodings belong to each decoder and are not kept here.
package io_wait_gen_pkg;

    localparam logic [7:0] VDP_PORT = 8'h98;
    localparam logic [7:0] PSG_PORT = 8'hA0;
    localparam logic [7:0] PPI_PORT = 8'hA8;
    localparam logic [7:0] IO_PORT_MASK = 8'hFC;

    // M1 low with IORQ low is an interrupt acknowledge, not an I/O access.
    function automatic logic io_access_match(
        input logic       niorq,
        input logic       nm1,
        input logic       nrd,
        input logic       nwr,
        input logic [7:0] addr,
        input logic [7:0] base,
        input logic [7:0] mask
    );
        return !niorq && nm1 && (!nrd || !nwr) && ((addr & mask) == (base & mask));
    endfunction

endpackage

// File: rtl/io_wait_gen_if.sv
// Z80 I/O bus strobes plus the chained active-low wait request.
interface io_wait_gen_if;

    logic       niorq;
    logic       nm1;
    logic       nrd;
    logic       nwr;
    logic [7:0] addr;
    logic       nextwait;
    logic       nwait;

    modport master (
        output niorq, nm1, nrd, nwr, addr, nextwait,
        input  nwait
    );

    modport slave (
        input  niorq, nm1, nrd, nwr, addr, nextwait,
        output nwait
    );

endinterface

// File: rtl/io_wait_gen.sv
// Inserts WAIT_CYCLES wait periods on Z80 I/O accesses to a matched port,
// merged with an upstream wait request.
module io_wait_gen
    import io_wait_gen_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [7:0]  PORT_BASE   = VDP_PORT,
    parameter logic [7:0]  PORT_MASK   = IO_PORT_MASK
) (
    input  logic          clk,
    input  logic          reset,
    io_wait_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Only the 0..15 range is meaningful; the 0 case never reaches the load.
    localparam logic [3:0] LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t     state;
    logic [3:0] cnt;
    logic       wait_q;
    logic       match;

    assign match = io_access_match(bus.niorq, bus.nm1, bus.nrd, bus.nwr,
                                   bus.addr, PORT_BASE, PORT_MASK);

    // NOTE: state, counter and wait term all use non-blocking assignments so every
    // branch reads the values from before this edge; blocking here would let a
    // later branch see a half-updated state and desynchronise the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            // HOLD keeps an access that is still on the bus from being re-waited.
            state  <= HOLD;
            cnt    <= 4'd0;
            wait_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        if (WAIT_CYCLES > 0) begin
                            state  <= COUNT;
                            cnt    <= LOAD;
                            wait_q <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                COUNT: begin
                    if (bus.niorq) begin
                        state  <= IDLE;
                        cnt    <= 4'd0;
                        wait_q <= 1'b0;
                    end else if (cnt == 4'd0) begin
                        state  <= HOLD;
                        wait_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (bus.niorq) state <= IDLE;
                end
                default: begin
                    state  <= HOLD;
                    cnt    <= 4'd0;
                    wait_q <= 1'b0;
                end
            endcase
        end
    end

    // Upstream wait passes straight through so the chain adds no latency.
    assign bus.nwait = bus.nextwait & ~wait_q;

endmodule

// File: tb/tb_io_wait_gen.sv
// Runs three io_wait_gen instances (2, 0 and 15 wait cycles) on one shared bus
// against a cycle-level wait-count model.
module tb_io_wait_gen;

    localparam int NDUT = 3;
    localparam int WCFG [NDUT] = '{2, 0, 15};

    logic       clk = 1'b0;
    logic       reset;
    logic       niorq, nm1, nrd, nwr, nextwait;
    logic [7:0] addr;

    int checks = 0;
    int errors = 0;

    // Model: periods of wait still owed per instance, and whether the current
    // access has already been served (or blocked by reset).
    int rem    [NDUT];
    bit served [NDUT];

    always #5 clk = ~clk;

    io_wait_gen_if bus_w2 ();
    io_wait_gen_if bus_w0 ();
    io_wait_gen_if bus_w15 ();

    assign bus_w2.niorq  = niorq;  assign bus_w0.niorq  = niorq;  assign bus_w15.niorq  = niorq;
    assign bus_w2.nm1    = nm1;    assign bus_w0.nm1    = nm1;    assign bus_w15.nm1    = nm1;
    assign bus_w2.nrd    = nrd;    assign bus_w0.nrd    = nrd;    assign bus_w15.nrd    = nrd;
    assign bus_w2.nwr    = nwr;    assign bus_w0.nwr    = nwr;    assign bus_w15.nwr    = nwr;
    assign bus_w2.addr   = addr;   assign bus_w0.addr   = addr;   assign bus_w15.addr   = addr;
    assign bus_w2.nextwait = nextwait;
    assign bus_w0.nextwait = nextwait;
    assign bus_w15.nextwait = nextwait;

    io_wait_gen #(.WAIT_CYCLES(2))  dut_w2  (.clk(clk), .reset(reset), .bus(bus_w2.slave));
    io_wait_gen #(.WAIT_CYCLES(0))  dut_w0  (.clk(clk), .reset(reset), .bus(bus_w0.slave));
    io_wait_gen #(.WAIT_CYCLES(15)) dut_w15 (.clk(clk), .reset(reset), .bus(bus_w15.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NDUT-1:0] dut_nwait();
        return {bus_w15.nwait, bus_w0.nwait, bus_w2.nwait};
    endfunction

    function automatic bit vdp_access();
        return niorq == 1'b0 && nm1 == 1'b1 && (nrd == 1'b0 || nwr == 1'b0)
               && addr >= 8'h98 && addr <= 8'h9B;
    endfunction

    task automatic model_step();
        for (int d = 0; d < NDUT; d++) begin
            if (reset) begin
                rem[d]    = 0;
                served[d] = 1'b1;
            end else if (rem[d] > 0) begin
                if (niorq) begin
                    rem[d]    = 0;
                    served[d] = 1'b0;
                end else begin
                    rem[d] = rem[d] - 1;
                end
            end else if (served[d]) begin
                if (niorq) served[d] = 1'b0;
            end else if (vdp_access()) begin
                rem[d]    = WCFG[d];
                served[d] = 1'b1;
            end
        end
    endtask

    // One clock: model advances on the edge, all outputs compared half a period later.
    task automatic cycle(output logic [NDUT-1:0] nw);
        @(posedge clk);
        model_step();
        @(negedge clk);
        nw = dut_nwait();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("nwait_w%0d", WCFG[d]), 32'(nw[d]),
                  32'(nextwait & (rem[d] == 0)));
        end
    endtask

    task automatic bus_idle();
        niorq = 1'b1; nm1 = 1'b1; nrd = 1'b1; nwr = 1'b1;
    endtask

    // Drives one access for len cycles with nextwait low on the first nw_low
    // cycles, then idles the bus; returns the count of low nwait cycles seen.
    task automatic access(input logic [7:0] a, input logic m1, input logic io,
                          input int len, input int nw_low, output int lows [NDUT]);
        logic [NDUT-1:0] nw;
        for (int d = 0; d < NDUT; d++) lows[d] = 0;
        addr = a; nm1 = m1; niorq = ~io; nwr = 1'b0; nrd = 1'b1;
        for (int i = 0; i < len; i++) begin
            nextwait = (i < nw_low) ? 1'b0 : 1'b1;
            cycle(nw);
            for (int d = 0; d < NDUT; d++) if (!nw[d]) lows[d]++;
        end
        bus_idle();
        nextwait = 1'b1;
        cycle(nw);
    endtask

    task automatic check_lows(input string tag, input int lows [NDUT], input int exp [NDUT]);
        for (int d = 0; d < NDUT; d++)
            check($sformatf("%s_w%0d", tag, WCFG[d]), 32'(lows[d]), 32'(exp[d]));
    endtask

    initial begin
        int lows [NDUT];
        logic [NDUT-1:0] nw;

        for (int d = 0; d < NDUT; d++) begin
            rem[d] = 0;
            served[d] = 1'b0;
        end
        bus_idle();
        addr = 8'h00; nextwait = 1'b1; reset = 1'b1;
        cycle(nw);
        cycle(nw);
        check("reset_nwait", 32'(nw), 32'(3'b111));
        reset = 1'b0;
        cycle(nw);

        // OUT (0x98) and boundary addresses of the decoded window.
        access(8'h98, 1'b1, 1'b1, 20, 0, lows);
        check_lows("out98", lows, '{2, 0, 15});
        access(8'h9B, 1'b1, 1'b1, 20, 0, lows);
        check_lows("out9b", lows, '{2, 0, 15});
        access(8'h9C, 1'b1, 1'b1, 20, 0, lows);
        check_lows("out9c", lows, '{0, 0, 0});
        access(8'h97, 1'b1, 1'b1, 20, 0, lows);
        check_lows("out97", lows, '{0, 0, 0});
        access(8'h98, 1'b0, 1'b1, 20, 0, lows);
        check_lows("inta", lows, '{0, 0, 0});
        access(8'h98, 1'b1, 1'b0, 20, 0, lows);
        check_lows("memcyc", lows, '{0, 0, 0});

        // Upstream wait while idle, then overlapping an inserted wait.
        access(8'h00, 1'b1, 1'b0, 6, 3, lows);
        check_lows("nextwait_idle", lows, '{3, 3, 3});
        access(8'h98, 1'b1, 1'b1, 20, 5, lows);
        check_lows("nextwait_count", lows, '{5, 5, 15});

        // Aborted access: IORQ released mid-count, wait must drop at once.
        access(8'h99, 1'b1, 1'b1, 4, 0, lows);
        check_lows("abort", lows, '{2, 0, 4});

        // Reset one edge after detection with the access still held.
        addr = 8'h98; nm1 = 1'b1; niorq = 1'b0; nwr = 1'b0;
        for (int d = 0; d < NDUT; d++) lows[d] = 0;
        for (int i = 0; i < 8; i++) begin
            reset = (i == 1);
            cycle(nw);
            for (int d = 0; d < NDUT; d++) if (!nw[d]) lows[d]++;
            if (i == 1) check("reset_release", 32'(nw), 32'(3'b111));
        end
        check_lows("reset_mid", lows, '{1, 0, 1});
        bus_idle();
        cycle(nw);
        access(8'h98, 1'b1, 1'b1, 20, 0, lows);
        check_lows("after_reset", lows, '{2, 0, 15});

        // Random bus traffic, every cycle compared against the model.
        for (int n = 0; n < 400; n++) begin
            int gap = $urandom_range(0, 3);
            int len = $urandom_range(1, 20);
            logic [7:0] pick [8] = '{8'h98, 8'h99, 8'h9A, 8'h9B, 8'h9C, 8'h97, 8'hA0, 8'h00};
            bus_idle();
            for (int g = 0; g < gap; g++) begin
                nextwait = ($urandom_range(0, 9) != 0);
                reset = ($urandom_range(0, 49) == 0);
                cycle(nw);
            end
            addr  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pick[$urandom_range(0, 7)];
            nm1   = ($urandom_range(0, 7) != 0);
            niorq = ($urandom_range(0, 5) == 0);
            nrd   = 1'($urandom);
            nwr   = nrd ? ($urandom_range(0, 5) == 0) : 1'b1;
            for (int i = 0; i < len; i++) begin
                nextwait = ($urandom_range(0, 9) != 0);
                reset = ($urandom_range(0, 49) == 0);
                cycle(nw);
            end
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
